// File: rtl/uart_rx_async_if.sv
// uart_rx_async_if: host-side bus of the UART receiver (baud tick, line, frame config, character and status).
interface uart_rx_async_if;
    logic       BAUD_TICK;
    logic       RX;
    logic       BIT8;
    logic       PARITY_EN;
    logic       ODD_N_EVEN;
    logic       READ_RX;
    logic [7:0] RX_DATA;
    logic       RX_READY;
    logic       PARITY_ERR;
    logic       FRAMING_ERR;
    logic       OVERFLOW;
    modport master (
        output BAUD_TICK, RX, BIT8, PARITY_EN, ODD_N_EVEN, READ_RX,
        input  RX_DATA, RX_READY, PARITY_ERR, FRAMING_ERR, OVERFLOW
    );
    modport slave (
        input  BAUD_TICK, RX, BIT8, PARITY_EN, ODD_N_EVEN, READ_RX,
        output RX_DATA, RX_READY, PARITY_ERR, FRAMING_ERR, OVERFLOW
    );
endinterface

// File: rtl/uart_rx_async.sv
// uart_rx_async: oversampled UART receiver with false-start rejection, optional parity and held-character status.
// Define RX_MAJORITY_VOTE_EN for 2-of-3 majority sampling around each bit centre.
module uart_rx_async #(
    parameter int SYNC_STAGES = 2,
    parameter int OVERSAMPLE  = 16
) (
    input logic            CLK,
    input logic            RESET,
    uart_rx_async_if.slave bus
);
    localparam int SCW = $clog2(OVERSAMPLE);
`ifdef RX_MAJORITY_VOTE_EN
    localparam int MV = 1;
`else
    localparam int MV = 0;
`endif
    // With voting, every decision moves one tick past the centre; the bit counter wraps naturally.
    localparam logic [SCW-1:0] START_ACT = SCW'(OVERSAMPLE / 2 - 1 + MV);
    localparam logic [SCW-1:0] BIT_ACT   = SCW'(OVERSAMPLE - 1 + MV);
    localparam logic [SCW-1:0] SC_ENTRY  = SCW'(MV);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SCW-1:0]         sc_q, sc_d;
    logic [2:0]             bc_q, bc_d;
    logic [7:0]             shift_q, shift_d;
    logic                   bit8_q, bit8_d;
    logic                   pen_q, pen_d;
    logic                   odd_q, odd_d;
    logic                   perr_q, perr_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_ready_q, rx_ready_d;
    logic                   parity_err_q, parity_err_d;
    logic                   framing_err_q, framing_err_d;
    logic                   overflow_q, overflow_d;
    logic                   rxs, smp, done;
    logic [7:0]             data_w;

    assign rxs    = sync_q[SYNC_STAGES-1];
    assign data_w = bit8_q ? shift_q : {1'b0, shift_q[7:1]};

`ifdef RX_MAJORITY_VOTE_EN
    logic [1:0] hist_q, hist_d;
    assign hist_d = bus.BAUD_TICK ? {hist_q[0], rxs} : hist_q;
    assign smp    = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
    always_ff @(posedge CLK) begin
        hist_q <= RESET ? 2'b11 : hist_d;
    end
`else
    assign smp = rxs;
`endif

    always_comb begin
        state_d       = state_q;
        sync_d        = {sync_q[SYNC_STAGES-2:0], bus.RX};
        sc_d          = sc_q;
        bc_d          = bc_q;
        shift_d       = shift_q;
        bit8_d        = bit8_q;
        pen_d         = pen_q;
        odd_d         = odd_q;
        perr_d        = perr_q;
        rx_data_d     = rx_data_q;
        rx_ready_d    = rx_ready_q;
        parity_err_d  = parity_err_q;
        framing_err_d = framing_err_q;
        overflow_d    = overflow_q;
        done          = 1'b0;
        if (bus.BAUD_TICK) begin
            sc_d = sc_q + 1'b1;
            case (state_q)
                IDLE: if (!rxs) begin
                    state_d = START;
                    sc_d    = '0;
                    bit8_d  = bus.BIT8;
                    pen_d   = bus.PARITY_EN;
                    odd_d   = bus.ODD_N_EVEN;
                    perr_d  = 1'b0;
                end
                START: if (sc_q == START_ACT) begin
                    state_d = smp ? IDLE : DATA;
                    sc_d    = SC_ENTRY;
                    bc_d    = '0;
                end
                DATA: if (sc_q == BIT_ACT) begin
                    shift_d = {smp, shift_q[7:1]};
                    bc_d    = bc_q + 1'b1;
                    if (bc_q == (bit8_q ? 3'd7 : 3'd6)) state_d = pen_q ? PARITY : STOP;
                end
                PARITY: if (sc_q == BIT_ACT) begin
                    perr_d  = smp ^ (^data_w) ^ odd_q;
                    state_d = STOP;
                end
                STOP: if (sc_q == BIT_ACT) begin
                    done    = 1'b1;
                    state_d = smp ? IDLE : BREAK_WAIT;
                end
                BREAK_WAIT: if (rxs) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        // A completing frame overrides a same-cycle host read.
        if (done) begin
            rx_data_d     = data_w;
            rx_ready_d    = 1'b1;
            parity_err_d  = pen_q & perr_q;
            framing_err_d = !smp;
            overflow_d    = rx_ready_q & !bus.READ_RX;
        end else if (bus.READ_RX) begin
            rx_ready_d    = 1'b0;
            parity_err_d  = 1'b0;
            framing_err_d = 1'b0;
            overflow_d    = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= IDLE;
            sync_q        <= '1;
            sc_q          <= '0;
            bc_q          <= '0;
            shift_q       <= '0;
            bit8_q        <= 1'b0;
            pen_q         <= 1'b0;
            odd_q         <= 1'b0;
            perr_q        <= 1'b0;
            rx_data_q     <= '0;
            rx_ready_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            sc_q          <= sc_d;
            bc_q          <= bc_d;
            shift_q       <= shift_d;
            bit8_q        <= bit8_d;
            pen_q         <= pen_d;
            odd_q         <= odd_d;
            perr_q        <= perr_d;
            rx_data_q     <= rx_data_d;
            rx_ready_q    <= rx_ready_d;
            parity_err_q  <= parity_err_d;
            framing_err_q <= framing_err_d;
            overflow_q    <= overflow_d;
        end
    end

    assign bus.RX_DATA     = rx_data_q;
    assign bus.RX_READY    = rx_ready_q;
    assign bus.PARITY_ERR  = parity_err_q;
    assign bus.FRAMING_ERR = framing_err_q;
    assign bus.OVERFLOW    = overflow_q;
endmodule
